clock_divisor_gen: RTL and testbench
====================================

# clock_divisor_gen

Parametrised successor to the I2C controller's fixed 4-bit clock divisor. It divides `clk_i` into a 50%-duty `clk_o` whose half-period is `clk_div + 1` input cycles. It reprograms the divisor on the fly only at period boundaries, so `clk_o` never has a runt pulse. It stops cleanly by finishing any high phase in progress. It feeds the SCL timing logic of the controller and, optionally, edge strobes for its bit-level FSM.

## Interface
- `DIV_W`, 4: divisor width in bits; legal range 2..16.
- `RESET_DIV`, `{DIV_W{1'b1}}`: value of `clk_div` after reset.
- `clk_i` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clk_en` input 1: run request; level-sensitive.
- `set_clk_div` input DIV_W: requested divisor; may change at any time.
- `clk_div` output DIV_W: divisor currently in use (registered).
- `clk_o` output 1: divided clock (registered).
- `busy` output 1: high whenever state is not IDLE.
- `rise_tick` output 1: 1-cycle strobe in the first `clk_i` cycle that `clk_o` is high.
- `fall_tick` output 1: 1-cycle strobe in the first `clk_i` cycle that `clk_o` is low after a fall.

## Operation
- Reset values:
  - state IDLE, `cnt`=0, `clk_o`=0, `clk_div`=RESET_DIV.
  - `busy`=0, `rise_tick`=0, `fall_tick`=0.
- States: IDLE, RUN, DRAIN.
- **IDLE**
  - `clk_o` is held at 0 and `cnt` at 0.
  - If `clk_en`=1: go to RUN, load `clk_div` <= `set_clk_div`, set `cnt` <= 0.
- **RUN, counting**
  - If `cnt` != `clk_div`: `cnt` <= `cnt`+1.
  - If `cnt` == `clk_div`: `cnt` <= 0 and `clk_o` toggles.
- **RUN, divisor reload**
  - Happens only on a high-to-low toggle, which is the period boundary: `clk_div` <= `set_clk_div` at the same edge.
  - The new value governs the following low phase.
  - `set_clk_div` changes at any other time have no effect until the next boundary.
- **RUN, `clk_en`=0**
  - If `clk_o`=0: go to IDLE with `cnt` <= 0. The low phase is truncated, with no glitch because `clk_o` stays low.
  - If `clk_o`=1: go to DRAIN. `cnt` keeps counting.
- **DRAIN**
  - Continues counting.
  - At `cnt` == `clk_div`, `clk_o` falls and the state goes to IDLE with `cnt` <= 0. `clk_div` is not reloaded.
  - `clk_en` is ignored during DRAIN. A reassertion is honoured from IDLE on the following cycle.
- Width rules:
  - `cnt` is DIV_W bits and never exceeds `clk_div`, so no wrap beyond `clk_div`.
  - `clk_div`=0 gives `clk_o` = `clk_i`/2.
  - `clk_div`=2^DIV_W−1 gives period 2^(DIV_W+1).
- Reset mid-operation: all outputs return to reset values asynchronously. `clk_o` may therefore be cut short; this is the only permitted runt.

## Timing
- IDLE→RUN on edge k; `clk_o` first rises at edge k+`clk_div`+1.
- Half-period is exactly `clk_div`+1 cycles; period is 2·(`clk_div`+1).
- `busy` rises the cycle after `clk_en` is sampled high in IDLE. It falls the cycle state enters IDLE.
- Ticks are registered and coincide with the `clk_o` change, not one cycle before it.
- `fall_tick` fires on the DRAIN completion fall.
- `fall_tick` does not fire on a RUN→IDLE exit taken while `clk_o`=0.
- Worst-case stop latency from `clk_en` low: `clk_div`+1 cycles.

## Configuration
- Macro: `CLOCK_DIVISOR_TICK_EN`.
- Defined: `rise_tick` and `fall_tick` are generated as described.
- Undefined: both ports remain present but are tied to 0, and the tick registers are removed.

## Structure
- Package `clock_divisor_pkg` holds:
  - the state encoding localparams `CD_IDLE`=2'd0, `CD_RUN`=2'd1, `CD_DRAIN`=2'd2;
  - the `CD_STATE_W`=2 width constant.
- No sub-module: the counter, FSM and reload register stay in one module.

## Test plan
- DIV_W=4, `set_clk_div`=3, `clk_en` 0→1 → `clk_o` period is 8 cycles with 4 high / 4 low, and `clk_div`=3.
- DIV_W=4, `set_clk_div` changed 3→7 mid high phase → current period completes at 8 cycles; the next low phase is 8 cycles; `clk_div` reads 7 from the falling edge.
- `clk_en` dropped 1 cycle into the high phase with `clk_div`=5 → DRAIN; `clk_o` falls 5 cycles later; `busy`=0 the cycle after; `fall_tick` pulses once.
- `clk_en` dropped during the low phase → IDLE next cycle, `clk_o` stays 0, no `fall_tick`; reassert → first rise `clk_div`+1 cycles later.
- DIV_W=8, `set_clk_div`=0 then 255 → period 2 cycles, then 512 cycles, with no intermediate runt pulse.
- `rst_n` pulsed low while `clk_o`=1 → `clk_o`=0, `clk_div`=RESET_DIV and `busy`=0 immediately; with the macro undefined, the ticks stay 0 throughout.

Source files
------------

// File: rtl/clock_divisor_gen_pkg.sv
// Shared state encoding for the clock divisor generator.
// The state type doubles as the encoding constants CD_IDLE/CD_RUN/CD_DRAIN.
package clock_divisor_pkg;

    localparam int CD_STATE_W = 2;

    typedef enum logic [CD_STATE_W-1:0] {
        CD_IDLE  = 2'd0,
        CD_RUN   = 2'd1,
        CD_DRAIN = 2'd2
    } cd_state_e;

endpackage

// File: rtl/clock_divisor_gen.sv
// Programmable 50%-duty clock divider with boundary-only divisor reload and clean stop.
// Optional edge strobes are built when CLOCK_DIVISOR_TICK_EN is defined; otherwise they are tied low.
module clock_divisor_gen
    import clock_divisor_pkg::*;
#(
    parameter int             DIV_W     = 4,
    parameter logic [DIV_W-1:0] RESET_DIV = {DIV_W{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic [DIV_W-1:0] set_clk_div,
    output logic [DIV_W-1:0] clk_div,
    output logic             clk_o,
    output logic             busy,
    output logic             rise_tick,
    output logic             fall_tick
);

    cd_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             clk_o_q, clk_o_d;
    logic             wrap;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        clk_o_d = clk_o_q;
        wrap    = (cnt_q == div_q);

        case (state_q)
            CD_IDLE: begin
                cnt_d   = '0;
                clk_o_d = 1'b0;
                if (clk_en) begin
                    state_d = CD_RUN;
                    div_d   = set_clk_div;
                end
            end
            CD_RUN: begin
                if (!clk_en && !clk_o_q) begin
                    // Truncating a low phase cannot glitch since clk_o stays low.
                    state_d = CD_IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    cnt_d   = '0;
                    clk_o_d = ~clk_o_q;
                    if (clk_o_q) begin
                        if (clk_en) div_d = set_clk_div;
                        else        state_d = CD_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!clk_en) state_d = CD_DRAIN;
                end
            end
            CD_DRAIN: begin
                if (wrap) begin
                    state_d = CD_IDLE;
                    cnt_d   = '0;
                    clk_o_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = CD_IDLE;
                cnt_d   = '0;
                clk_o_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CD_IDLE;
            cnt_q   <= '0;
            div_q   <= RESET_DIV;
            clk_o_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            clk_o_q <= clk_o_d;
        end
    end

    assign clk_div = div_q;
    assign clk_o   = clk_o_q;
    assign busy    = (state_q != CD_IDLE);

`ifdef CLOCK_DIVISOR_TICK_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Strobes are registered alongside clk_o so they line up with its change.
    always_comb begin
        rise_d = clk_o_d & ~clk_o_q;
        fall_d = ~clk_o_d & clk_o_q;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_tick = rise_q;
    assign fall_tick = fall_q;
`else
    assign rise_tick = 1'b0;
    assign fall_tick = 1'b0;
`endif

endmodule

// File: tb/tb_clock_divisor_gen.sv
// Bench for clock_divisor_gen: a 4-bit and an 8-bit instance share stimulus and are
// compared every cycle against a phase-length model; honours CLOCK_DIVISOR_TICK_EN.
module tb_clock_divisor_gen;

`ifdef CLOCK_DIVISOR_TICK_EN
  localparam bit TICKS = 1'b1;
`else
  localparam bit TICKS = 1'b0;
`endif
  localparam int VW = 24;
  localparam logic [VW-1:0] RST_VEC = 24'h0FF00F;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic [7:0] set_div = 8'd0;

  logic [3:0] div0;
  logic [7:0] div1;
  logic       clk_o0, busy0, rt0, ft0;
  logic       clk_o1, busy1, rt1, ft1;

  int checks = 0;
  int errors = 0;

  // Model: per instance, whether running/draining, output level, edges left in phase.
  bit m_run[2], m_drn[2], m_lvl[2], m_rt[2], m_ft[2];
  int m_left[2], m_div[2];
  int rdiv[2] = '{15, 255};
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] e_v;

  always #5 clk_i = ~clk_i;

  clock_divisor_gen #(.DIV_W(4)) u_dut0 (
    .clk_i(clk_i), .rst_n(rst_n), .clk_en(clk_en), .set_clk_div(set_div[3:0]),
    .clk_div(div0), .clk_o(clk_o0), .busy(busy0), .rise_tick(rt0), .fall_tick(ft0)
  );

  clock_divisor_gen #(.DIV_W(8)) u_dut1 (
    .clk_i(clk_i), .rst_n(rst_n), .clk_en(clk_en), .set_clk_div(set_div),
    .clk_div(div1), .clk_o(clk_o1), .busy(busy1), .rise_tick(rt1), .fall_tick(ft1)
  );

  function automatic logic [VW-1:0] obs();
    return {clk_o1, busy1, rt1, ft1, div1, clk_o0, busy0, rt0, ft0, 4'b0, div0};
  endfunction

  function automatic logic [11:0] mexp(int i);
    return {m_lvl[i], m_run[i] | m_drn[i], m_rt[i] & TICKS, m_ft[i] & TICKS, 8'(m_div[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_drn[i] = 0; m_lvl[i] = 0; m_rt[i] = 0; m_ft[i] = 0;
      m_left[i] = 0; m_div[i] = rdiv[i];
    end
  endtask

  task automatic model_edge(int i, bit en, int setv);
    m_rt[i] = 0;
    m_ft[i] = 0;
    if (!m_run[i] && !m_drn[i]) begin
      if (en) begin
        m_run[i] = 1; m_div[i] = setv; m_left[i] = setv + 1; m_lvl[i] = 0;
      end
    end else if (m_run[i] && !en && !m_lvl[i]) begin
      m_run[i] = 0;
    end else begin
      if (m_run[i] && !en) begin m_run[i] = 0; m_drn[i] = 1; end
      m_left[i]--;
      if (m_left[i] == 0) begin
        if (m_lvl[i]) begin
          m_lvl[i] = 0; m_ft[i] = 1;
          if (m_drn[i]) m_drn[i] = 0;
          else begin m_div[i] = setv; m_left[i] = setv + 1; end
        end else begin
          m_lvl[i] = 1; m_rt[i] = 1; m_left[i] = m_div[i] + 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (rst_n) begin
      model_edge(0, clk_en, int'(set_div[3:0]));
      model_edge(1, clk_en, int'(set_div));
    end
    exp_q.push_back({mexp(1), mexp(0)});
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b0; set_div = 8'd0;
    model_reset();
    #12;
    checks++;
    if (obs() !== RST_VEC) begin
      errors++; $display("FAIL reset_vals got %h exp %h", obs(), RST_VEC);
    end
    @(negedge clk_i);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL reset_idle t=%0t got %h exp %h", $time, obs(), e_v); end
    end
  endtask

  task automatic test_basic();
    int t_r[$], t_f[$];
    logic p;
    set_div = 8'd3; clk_en = 1'b1;
    p = clk_o0;
    for (int c = 0; c < 40; c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL basic t=%0t got %h exp %h", $time, obs(), e_v); end
      if (clk_o0 && !p) t_r.push_back(c);
      if (!clk_o0 && p) t_f.push_back(c);
      p = clk_o0;
    end
    checks++;
    if (t_r.size() < 2 || t_f.size() < 1) begin
      errors++; $display("FAIL basic_edges got rises %0d falls %0d exp >=2 >=1", t_r.size(), t_f.size());
    end else begin
      checks++;
      if (t_r[0] != 4) begin errors++; $display("FAIL basic_first_rise got %0d exp 4", t_r[0]); end
      checks++;
      if (t_r[1] - t_r[0] != 8) begin errors++; $display("FAIL basic_period got %0d exp 8", t_r[1] - t_r[0]); end
      checks++;
      if (t_f[0] - t_r[0] != 4) begin errors++; $display("FAIL basic_high got %0d exp 4", t_f[0] - t_r[0]); end
    end
    checks++;
    if (div0 !== 4'd3) begin errors++; $display("FAIL basic_div got %0d exp 3", div0); end
  endtask

  task automatic test_reload();
    int f = -1, r = -1;
    logic p;
    bit seen = 0;
    logic [3:0] d_fall = 4'd0;
    p = clk_o0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL reload_wait t=%0t got %h exp %h", $time, obs(), e_v); end
      if (clk_o0 && !p) seen = 1;
      p = clk_o0;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reload_rise_timeout got none exp rise"); end
    set_div = 8'd7;
    for (int c = 1; c < 30; c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL reload t=%0t got %h exp %h", $time, obs(), e_v); end
      if (!clk_o0 && p && f < 0) begin f = c; d_fall = div0; end
      if (clk_o0 && !p && f >= 0 && r < 0) r = c;
      p = clk_o0;
    end
    checks++;
    if (f != 4) begin errors++; $display("FAIL reload_high got %0d exp 4", f); end
    checks++;
    if (d_fall !== 4'd7) begin errors++; $display("FAIL reload_div_at_fall got %0d exp 7", d_fall); end
    checks++;
    if (r - f != 8) begin errors++; $display("FAIL reload_low got %0d exp 8", r - f); end
  endtask

  task automatic test_drain();
    logic p;
    bit seen = 0;
    int n = -1, fts = 0;
    logic b_at_fall = 1'b1;
    clk_en = 1'b0;
    for (int c = 0; c < 40 && busy0; c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL drain_stop t=%0t got %h exp %h", $time, obs(), e_v); end
    end
    set_div = 8'd5; clk_en = 1'b1;
    p = clk_o0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL drain_wait t=%0t got %h exp %h", $time, obs(), e_v); end
      if (clk_o0 && !p) seen = 1;
      p = clk_o0;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL drain_rise_timeout got none exp rise"); end
    tick(); e_v = exp_q.pop_front(); checks++;
    if (obs() !== e_v) begin errors++; $display("FAIL drain_hi t=%0t got %h exp %h", $time, obs(), e_v); end
    clk_en = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL drain t=%0t got %h exp %h", $time, obs(), e_v); end
      if (ft0) fts++;
      if (!clk_o0 && n < 0) begin n = c; b_at_fall = busy0; end
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL drain_latency got %0d exp 5", n); end
    checks++;
    if (b_at_fall !== 1'b0) begin errors++; $display("FAIL drain_busy got %b exp 0", b_at_fall); end
    checks++;
    if (fts != int'(TICKS)) begin errors++; $display("FAIL drain_fall_tick got %0d exp %0d", fts, int'(TICKS)); end
  endtask

  task automatic test_low_stop();
    logic p;
    bit seen = 0;
    int n = -1;
    clk_en = 1'b1;
    p = clk_o0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL lowstop_wait t=%0t got %h exp %h", $time, obs(), e_v); end
      if (!clk_o0 && p) seen = 1;
      p = clk_o0;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL lowstop_fall_timeout got none exp fall"); end
    tick(); e_v = exp_q.pop_front(); checks++;
    if (obs() !== e_v) begin errors++; $display("FAIL lowstop_lo t=%0t got %h exp %h", $time, obs(), e_v); end
    clk_en = 1'b0;
    tick(); e_v = exp_q.pop_front(); checks++;
    if (obs() !== e_v) begin errors++; $display("FAIL lowstop t=%0t got %h exp %h", $time, obs(), e_v); end
    checks++;
    if ({busy0, clk_o0, ft0} !== 3'b000) begin
      errors++; $display("FAIL lowstop_idle got busy,clk_o,fall=%b exp 000", {busy0, clk_o0, ft0});
    end
    clk_en = 1'b1;
    p = clk_o0;
    for (int c = 0; c < 20 && n < 0; c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL lowstop_restart t=%0t got %h exp %h", $time, obs(), e_v); end
      if (clk_o0 && !p) n = c;
      p = clk_o0;
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL lowstop_first_rise got %0d exp 6", n); end
  endtask

  task automatic test_div8();
    logic p;
    int tog = 0, len = 0, bad = 0, long_seen = 0;
    clk_en = 1'b0;
    for (int c = 0; c < 600 && (busy0 || busy1); c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL div8_stop t=%0t got %h exp %h", $time, obs(), e_v); end
    end
    set_div = 8'd0; clk_en = 1'b1;
    p = clk_o1;
    for (int c = 0; c < 12; c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL div8_fast t=%0t got %h exp %h", $time, obs(), e_v); end
      if (clk_o1 != p) tog++;
      p = clk_o1;
    end
    checks++;
    if (tog != 11) begin errors++; $display("FAIL div8_toggles got %0d exp 11", tog); end
    set_div = 8'd255;
    for (int c = 0; c < 1100; c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL div8_slow t=%0t got %h exp %h", $time, obs(), e_v); end
      len++;
      if (clk_o1 != p) begin
        if (len != 1 && len != 256) bad++;
        if (len == 256) long_seen++;
        len = 0;
      end
      p = clk_o1;
    end
    checks++;
    if (bad != 0 || long_seen < 2) begin
      errors++; $display("FAIL div8_phases got odd=%0d long=%0d exp odd=0 long>=2", bad, long_seen);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    set_div = 8'd15; clk_en = 1'b1;
    for (int c = 0; c < 600 && !seen; c++) begin
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL rstmid_wait t=%0t got %h exp %h", $time, obs(), e_v); end
      if (clk_o0) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_high_timeout got none exp clk_o high"); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== RST_VEC) begin errors++; $display("FAIL rstmid_vals got %h exp %h", obs(), RST_VEC); end
    tick(); e_v = exp_q.pop_front(); checks++;
    if (obs() !== e_v) begin errors++; $display("FAIL rstmid_hold t=%0t got %h exp %h", $time, obs(), e_v); end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) clk_en = ~clk_en;
      if ($urandom_range(0, 9) == 0)
        set_div = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs() !== RST_VEC) begin errors++; $display("FAIL rand_rst got %h exp %h", obs(), RST_VEC); end
      end
      tick(); e_v = exp_q.pop_front(); checks++;
      if (obs() !== e_v) begin errors++; $display("FAIL rand t=%0t got %h exp %h", $time, obs(), e_v); end
      rst_n = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_drain();
    test_low_stop();
    test_div8();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
